eth_rx_frame_buffer: RTL and testbench



---
 rtl/eth_rx_frame_buffer.sv | 178 +++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: frames are written speculatively and released
// whole on commit; the reader streams one frame per out_ready grant with no gaps.
module eth_rx_frame_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int MAX_FRAMES = 32,
  parameter int LEN_WIDTH  = 12,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int BVW       = $clog2(BYTES) + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_start,
  input  logic                  in_data_valid,
  input  logic [BVW-1:0]        in_bytes_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_commit,
  input  logic                  in_drop,
  input  logic                  out_ready,
  output logic                  out_start,
  output logic                  out_data_valid,
  output logic [BVW-1:0]        out_bytes_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_commit,
  output logic [63:0]           perf_frames_out,
  output logic [63:0]           perf_frames_dropped,
  output logic [63:0]           perf_frames_overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int FAW = $clog2(MAX_FRAMES);
  localparam int FPW = FAW + 1;
  localparam int RW  = BVW + DATA_WIDTH;
  localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);
  localparam logic [FPW-1:0]       FRAMES_P = FPW'(MAX_FRAMES);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {IDLE, START, DATA, COMMIT} state_t;

  logic [RW-1:0]        mem [DEPTH];
  logic [RW-1:0]        ram_q;
  logic [LEN_WIDTH-1:0] desc_mem [MAX_FRAMES];
  logic [FPW-1:0]       desc_wp, desc_rp;

  logic [PW-1:0]        wr_ptr, commit_ptr, rd_ptr;
  logic [AW-1:0]        ra_ptr;
  logic [LEN_WIDTH-1:0] frame_len, rd_remain, reads_left;
  logic                 ovf;
  state_t               state, state_nxt;

  logic [PW-1:0]        wp0, wp1, free0;
  logic [LEN_WIDTH-1:0] fl0, fl1, desc_len;
  logic                 ov0, ov1, wr_en, desc_full, desc_empty;
  logic                 commit_ok, commit_bad, desc_pop, ram_rd;
  logic [AW-1:0]        rd_addr;

  assign desc_full  = (desc_wp - desc_rp) == FRAMES_P;
  assign desc_empty = desc_wp == desc_rp;
  assign desc_len   = desc_mem[desc_rp[FAW-1:0]];

  // in_start rewinds before the same-cycle word is considered, so that word becomes word 0.
  always_comb begin
    wp0        = in_start ? commit_ptr : wr_ptr;
    fl0        = in_start ? '0 : frame_len;
    ov0        = in_start ? 1'b0 : ovf;
    free0      = DEPTH_P - (wp0 - rd_ptr);
    wr_en      = in_data_valid && !ov0 && (free0 != '0) && (fl0 != LEN_MAX);
    wp1        = wp0 + PW'(wr_en);
    fl1        = fl0 + LEN_WIDTH'(wr_en);
    ov1        = ov0 | (in_data_valid & ~wr_en);
    commit_ok  = in_commit && !in_drop && !ov1 && !desc_full && (fl1 != '0);
    commit_bad = in_commit && !in_drop && !commit_ok;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr               <= '0;
      commit_ptr           <= '0;
      frame_len            <= '0;
      ovf                  <= 1'b0;
      desc_wp              <= '0;
      perf_frames_dropped  <= '0;
      perf_frames_overflow <= '0;
    end else begin
      wr_ptr    <= wp1;
      frame_len <= fl1;
      ovf       <= ov1;
      if (in_drop || commit_bad) begin
        wr_ptr    <= commit_ptr;
        frame_len <= '0;
        ovf       <= 1'b0;
      end else if (commit_ok) begin
        commit_ptr <= wp1;
        frame_len  <= '0;
        desc_wp    <= desc_wp + 1'b1;
      end
      if (in_drop)    perf_frames_dropped  <= perf_frames_dropped + 64'd1;
      if (commit_bad) perf_frames_overflow <= perf_frames_overflow + 64'd1;
    end
  end

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge sys_clk) begin
    if (wr_en)     mem[wp0[AW-1:0]] <= {in_bytes_valid, in_data};
    if (commit_ok) desc_mem[desc_wp[FAW-1:0]] <= fl1;
    if (ram_rd)    ram_q <= mem[rd_addr];
  end

  always_comb begin
    state_nxt      = state;
    desc_pop       = 1'b0;
    ram_rd         = 1'b0;
    rd_addr        = ra_ptr;
    out_start      = 1'b0;
    out_data_valid = 1'b0;
    out_commit     = 1'b0;
    case (state)
      IDLE: begin
        if (!desc_empty && out_ready) begin
          desc_pop  = 1'b1;
          ram_rd    = 1'b1;
          rd_addr   = rd_ptr[AW-1:0];
          state_nxt = START;
        end
      end
      START: begin
        out_start = 1'b1;
        ram_rd    = reads_left != '0;
        state_nxt = DATA;
      end
      DATA: begin
        out_data_valid = 1'b1;
        ram_rd         = reads_left != '0;
        if (rd_remain == LEN_WIDTH'(1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        out_commit = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM output is re-registered so word k is presented while word k+1 is being read.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      rd_ptr          <= '0;
      ra_ptr          <= '0;
      rd_remain       <= '0;
      reads_left      <= '0;
      desc_rp         <= '0;
      out_data        <= '0;
      out_bytes_valid <= '0;
      perf_frames_out <= '0;
    end else begin
      state <= state_nxt;
      if (desc_pop) begin
        rd_remain  <= desc_len;
        reads_left <= desc_len - 1'b1;
        ra_ptr     <= rd_ptr[AW-1:0] + 1'b1;
        desc_rp    <= desc_rp + 1'b1;
      end else if (ram_rd) begin
        ra_ptr     <= ra_ptr + 1'b1;
        reads_left <= reads_left - 1'b1;
      end
      if (state == START) {out_bytes_valid, out_data} <= ram_q;
      if (state == DATA) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_remain <= rd_remain - 1'b1;
        if (rd_remain != LEN_WIDTH'(1)) {out_bytes_valid, out_data} <= ram_q;
      end
      if (state == COMMIT) perf_frames_out <= perf_frames_out + 64'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: queue-based frame model scheduled in time, a per-cycle
// output compare, and directed scenarios with literal expectations.
module tb_eth_rx_frame_buffer;

  localparam int DEP = 16;
  localparam int MF  = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst, in_start, in_data_valid, in_commit, in_drop, out_ready;
  logic [2:0]  in_bytes_valid, out_bytes_valid;
  logic [31:0] in_data, out_data;
  logic        out_start, out_data_valid, out_commit;
  logic [63:0] perf_frames_out, perf_frames_dropped, perf_frames_overflow;

  eth_rx_frame_buffer #(.DATA_WIDTH(32), .DEPTH(DEP), .MAX_FRAMES(MF), .LEN_WIDTH(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_start(in_start), .in_data_valid(in_data_valid),
    .in_bytes_valid(in_bytes_valid), .in_data(in_data), .in_commit(in_commit), .in_drop(in_drop),
    .out_ready(out_ready), .out_start(out_start), .out_data_valid(out_data_valid),
    .out_bytes_valid(out_bytes_valid), .out_data(out_data), .out_commit(out_commit),
    .perf_frames_out(perf_frames_out), .perf_frames_dropped(perf_frames_dropped),
    .perf_frames_overflow(perf_frames_overflow));

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic st; logic dv; logic [2:0] bv; logic [31:0] d; logic cm;
  } ev_t;

  ev_t         sched [64];
  logic [34:0] open_q[$];
  logic [34:0] wq[$];
  int          lens[$];
  int          stored, next_free;
  bit          m_ovf, chk_en;
  longint      m_out, m_drop, m_ovfc;
  int          cyc = 0, errors = 0, checks = 0, c_in = 0;
  int          n_start = 0, n_commit = 0, last_commit_cyc = 0, fw = 0, last_fw = 0;
  int          st_hist[$];

  // Expected output timeline: a frame granted at cycle T shows start at T+1,
  // its words at T+2.., commit after the last word, and the reader is free at T+3+L.
  task automatic model_step();
    int k, len;
    bit full;
    logic [34:0] w;
    k = cyc;
    if (sys_rst) begin
      open_q.delete(); wq.delete(); lens.delete();
      stored = 0; m_ovf = 0; m_out = 0; m_drop = 0; m_ovfc = 0; next_free = k + 1;
      for (int i = 0; i < 64; i++) sched[i] = '0;
    end else begin
      full = (lens.size() == MF);
      if (k >= next_free && lens.size() != 0 && out_ready) begin
        len = lens.pop_front();
        sched[(k + 1) % 64].st = 1'b1;
        for (int i = 0; i < len; i++) begin
          w = wq.pop_front();
          sched[(k + 2 + i) % 64].dv = 1'b1;
          sched[(k + 2 + i) % 64].bv = w[34:32];
          sched[(k + 2 + i) % 64].d  = w[31:0];
        end
        sched[(k + 2 + len) % 64].cm = 1'b1;
        next_free = k + 3 + len;
      end
      if (in_start) begin open_q.delete(); m_ovf = 0; end
      if (in_data_valid) begin
        if (!m_ovf && (DEP - stored - open_q.size()) != 0 && open_q.size() != 31)
          open_q.push_back({in_bytes_valid, in_data});
        else
          m_ovf = 1;
      end
      if (in_drop) begin
        open_q.delete(); m_ovf = 0; m_drop++;
      end else if (in_commit) begin
        if (m_ovf || full || open_q.size() == 0) m_ovfc++;
        else begin
          lens.push_back(open_q.size());
          foreach (open_q[i]) wq.push_back(open_q[i]);
          stored += open_q.size();
        end
        open_q.delete(); m_ovf = 0;
      end
      if (sched[k % 64].dv) stored--;
      if (sched[k % 64].cm) m_out++;
      sched[k % 64] = '0;
    end
    cyc = cyc + 1;
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
  end

  initial forever begin
    ev_t e;
    @(negedge sys_clk);
    if (chk_en) begin
      e = sched[cyc % 64];
      checks++;
      if (out_start !== e.st || out_data_valid !== e.dv || out_commit !== e.cm ||
          (e.dv && (out_bytes_valid !== e.bv || out_data !== e.d))) begin
        errors++;
        $display("FAIL out_stream cyc=%0d got s/v/c=%b%b%b bv=%0d data=%h want s/v/c=%b%b%b bv=%0d data=%h",
                 cyc, out_start, out_data_valid, out_commit, out_bytes_valid, out_data,
                 e.st, e.dv, e.cm, e.bv, e.d);
      end
      checks++;
      if (perf_frames_out !== m_out || perf_frames_dropped !== m_drop ||
          perf_frames_overflow !== m_ovfc) begin
        errors++;
        $display("FAIL perf cyc=%0d got out/drop/ovf=%0d/%0d/%0d want %0d/%0d/%0d", cyc,
                 perf_frames_out, perf_frames_dropped, perf_frames_overflow, m_out, m_drop, m_ovfc);
      end
      if (out_start) begin n_start++; st_hist.push_back(cyc); fw = 0; end
      if (out_data_valid) fw++;
      if (out_commit) begin n_commit++; last_commit_cyc = cyc; last_fw = fw; end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit dv, input logic [2:0] bv, input logic [31:0] d,
                       input bit cm, input bit dr);
    in_start = st; in_data_valid = dv; in_bytes_valid = bv; in_data = d;
    in_commit = cm; in_drop = dr;
    tick();
    in_start = 0; in_data_valid = 0; in_commit = 0; in_drop = 0;
  endtask

  task automatic frame(input int n, input logic [31:0] base, input logic [2:0] lastbv,
                       input bit cm_last, input bit st_first);
    if (!st_first) drive(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (cm_last && i == n - 1) c_in = cyc;
      drive(st_first && i == 0, 1'b1, (i == n - 1) ? lastbv : 3'd4, base + 32'(i),
            cm_last && i == n - 1, 1'b0);
    end
  endtask

  task automatic commit_frame();
    c_in = cyc;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (!(lens.size() == 0 && cyc > next_free + 1) && w < 300) begin
      tick();
      w++;
    end
    chk("drain_timeout", int'(w < 300), 1);
  endtask

  initial begin
    int n0, nc0, w, n;
    sys_rst = 1; in_start = 0; in_data_valid = 0; in_bytes_valid = 0; in_data = 0;
    in_commit = 0; in_drop = 0; out_ready = 1;
    repeat (3) tick();
    sys_rst = 0;
    chk("rst_ctrl", int'({out_start, out_data_valid, out_commit}), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_bv", int'(out_bytes_valid), 0);
    chk("rst_perf", int'(perf_frames_out + perf_frames_dropped + perf_frames_overflow), 0);
    chk_en = 1;

    frame(16, 32'hA000_0000, 3'd2, 1'b0, 1'b0);
    commit_frame();
    wait_drain();
    chk("single_start_lat", st_hist[st_hist.size() - 1] - c_in, 2);
    chk("single_commit_lat", last_commit_cyc - c_in, 19);
    chk("single_words", last_fw, 16);
    chk("single_frames_out", int'(perf_frames_out), 1);

    frame(8, 32'hB000_0000, 3'd4, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    frame(4, 32'hC000_0000, 3'd3, 1'b0, 1'b0);
    commit_frame();
    wait_drain();
    chk("drop_count", int'(perf_frames_dropped), 1);
    chk("drop_frames_out", int'(perf_frames_out), 2);
    chk("drop_commit_ptr", int'(dut.commit_ptr), 20);
    chk("drop_words", last_fw, 4);

    out_ready = 0;
    n0 = n_start;
    frame(10, 32'hD000_0000, 3'd4, 1'b0, 1'b0);
    commit_frame();
    frame(10, 32'hE000_0000, 3'd4, 1'b0, 1'b0);
    commit_frame();
    tick();
    chk("ovf_count", int'(perf_frames_overflow), 1);
    frame(6, 32'hF000_0000, 3'd1, 1'b0, 1'b0);
    commit_frame();
    chk("ovf_held", n_start - n0, 0);
    out_ready = 1;
    wait_drain();
    chk("ovf_frames_out", int'(perf_frames_out), 4);
    chk("ovf_last_words", last_fw, 6);

    out_ready = 0;
    n0 = n_start;
    frame(2, 32'h1100_0000, 3'd4, 1'b1, 1'b0);
    frame(3, 32'h2200_0000, 3'd2, 1'b1, 1'b0);
    frame(1, 32'h3300_0000, 3'd1, 1'b1, 1'b0);
    repeat (5) tick();
    chk("bp_no_start", n_start - n0, 0);
    out_ready = 1;
    wait_drain();
    n = st_hist.size();
    chk("bp_starts", n_start - n0, 3);
    chk("bp_gap1", st_hist[n - 2] - st_hist[n - 3], 5);
    chk("bp_gap2", st_hist[n - 1] - st_hist[n - 2], 6);
    chk("bp_frames_out", int'(perf_frames_out), 7);

    out_ready = 0;
    for (int i = 0; i < 5; i++) frame(1, 32'h4400_0000 + 32'(i), 3'd4, 1'b1, 1'b0);
    tick();
    chk("desc_full_ovf", int'(perf_frames_overflow), 2);
    out_ready = 1;
    wait_drain();
    chk("desc_full_out", int'(perf_frames_out), 11);

    frame(3, 32'h5500_0000, 3'd1, 1'b1, 1'b1);
    wait_drain();
    chk("same_cycle_words", last_fw, 3);
    chk("same_cycle_out", int'(perf_frames_out), 12);
    frame(2, 32'h6600_0000, 3'd4, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
    chk("drop_wins_drop", int'(perf_frames_dropped), 2);
    chk("drop_wins_ovf", int'(perf_frames_overflow), 2);
    wait_drain();
    chk("drop_wins_out", int'(perf_frames_out), 12);

    frame(12, 32'h7700_0000, 3'd4, 1'b0, 1'b0);
    commit_frame();
    w = 0;
    while (!out_data_valid && w < 40) begin tick(); w++; end
    chk("rst_mid_data_seen", int'(out_data_valid), 1);
    repeat (2) tick();
    nc0 = n_commit;
    sys_rst = 1;
    tick();
    sys_rst = 0;
    chk("rst_mid_valid", int'(out_data_valid), 0);
    chk("rst_mid_perf", int'(perf_frames_out + perf_frames_dropped + perf_frames_overflow), 0);
    repeat (20) tick();
    chk("rst_mid_no_commit", n_commit - nc0, 0);
    frame(2, 32'h8800_0000, 3'd3, 1'b1, 1'b0);
    wait_drain();
    chk("post_rst_out", int'(perf_frames_out), 1);
    chk("post_rst_words", last_fw, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
